// File: rtl/lock_ctrl.sv
// Keypad lock sequencer: digit entry, code check, timed unlock, fail lockout and reprogramming.
// Define LOCK_ENTRY_TIMEOUT_EN to discard partial entries after ENTRY_TIMEOUT idle cycles.
//
// state   | meaning
// ENTRY   | collecting digits of an unlock attempt
// CHECK   | one cycle comparing the full entry against the stored code
// OPEN    | unlock pulse running on the shared timer
// PROG    | collecting a replacement code
// LOCKOUT | too many failures, digits ignored until the timer expires
module lock_ctrl #(
    parameter int                  DIGITS         = 4,
    parameter logic [4*DIGITS-1:0] DEFAULT_CODE   = 16'h0568,
    parameter int                  UNLOCK_CYCLES  = 16,
    parameter int                  MAX_FAILS      = 3,
    parameter int                  LOCKOUT_CYCLES = 64,
    parameter int                  ENTRY_TIMEOUT  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic       key_ready,
    input  logic       key_clear,
    input  logic       prog_en,
    output logic       unlock,
    output logic       locked_out,
    output logic [3:0] fail_cnt,
    output logic [2:0] digit_cnt,
    output logic [2:0] state
);
    localparam int EW     = 4 * DIGITS;
    localparam int T_MAX0 = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int T_MAX  = (ENTRY_TIMEOUT > T_MAX0) ? ENTRY_TIMEOUT : T_MAX0;
    localparam int TW     = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] T_UNLOCK = TW'(UNLOCK_CYCLES);
    localparam logic [TW-1:0] T_LOCK   = TW'(LOCKOUT_CYCLES);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [2:0]    LAST     = 3'(DIGITS - 1);
    localparam logic [3:0]    MAXF     = 4'(MAX_FAILS);
`ifdef LOCK_ENTRY_TIMEOUT_EN
    localparam logic [TW-1:0] T_ENTRY  = TW'(ENTRY_TIMEOUT);
`endif

    typedef enum logic [2:0] {
        ENTRY   = 3'd0,
        CHECK   = 3'd1,
        OPEN    = 3'd2,
        PROG    = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [EW-1:0] code_q, code_d, entry_q, entry_d, shifted;
    logic [2:0]    digit_cnt_q, digit_cnt_d;
    logic [3:0]    fail_cnt_q, fail_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          unlock_q, locked_out_q;
    logic          accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ENTRY;
            code_q       <= DEFAULT_CODE;
            entry_q      <= '0;
            digit_cnt_q  <= '0;
            fail_cnt_q   <= '0;
            timer_q      <= '0;
            unlock_q     <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            entry_q      <= entry_d;
            digit_cnt_q  <= digit_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            timer_q      <= timer_d;
            unlock_q     <= (state_d == OPEN);
            locked_out_q <= (state_d == LOCKOUT);
        end
    end

    assign key_ready = (state_q == ENTRY) || (state_q == PROG);
    assign accept    = key_valid && key_ready;
    // Oldest digit ends up in the MS nibble; truncation drops the digit shifted out.
    assign shifted   = EW'({entry_q, key_digit});

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        entry_d     = entry_q;
        digit_cnt_d = digit_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        timer_d     = timer_q;
        case (state_q)
            ENTRY, PROG: begin
                if (key_clear) begin
                    entry_d     = '0;
                    digit_cnt_d = '0;
                    if (state_q == PROG) state_d = ENTRY;
                end else if (accept) begin
                    entry_d = shifted;
                    if (digit_cnt_q == LAST) begin
                        digit_cnt_d = '0;
                        if (state_q == ENTRY) begin
                            state_d = CHECK;
                        end else begin
                            code_d     = shifted;
                            entry_d    = '0;
                            fail_cnt_d = '0;
                            state_d    = ENTRY;
                        end
                    end else begin
                        digit_cnt_d = digit_cnt_q + 3'd1;
`ifdef LOCK_ENTRY_TIMEOUT_EN
                        timer_d     = T_ENTRY;
`endif
                    end
                end
`ifdef LOCK_ENTRY_TIMEOUT_EN
                else if (digit_cnt_q != '0) begin
                    if (timer_q <= T_ONE) begin
                        entry_d     = '0;
                        digit_cnt_d = '0;
                        timer_d     = '0;
                        if (state_q == PROG) state_d = ENTRY;
                    end else begin
                        timer_d = timer_q - T_ONE;
                    end
                end
`endif
            end
            CHECK: begin
                entry_d = '0;
                if (entry_q == code_q) begin
                    state_d    = OPEN;
                    fail_cnt_d = '0;
                    timer_d    = T_UNLOCK;
                end else if (fail_cnt_q + 4'd1 == MAXF) begin
                    state_d    = LOCKOUT;
                    fail_cnt_d = MAXF;
                    timer_d    = T_LOCK;
                end else begin
                    state_d    = ENTRY;
                    fail_cnt_d = fail_cnt_q + 4'd1;
                end
            end
            OPEN: begin
                if (prog_en) begin
                    state_d = PROG;
                    timer_d = '0;
                end else if (timer_q <= T_ONE) begin
                    state_d = ENTRY;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            LOCKOUT: begin
                if (timer_q <= T_ONE) begin
                    state_d    = ENTRY;
                    fail_cnt_d = '0;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            default: state_d = ENTRY;
        endcase
    end

    assign unlock     = unlock_q;
    assign locked_out = locked_out_q;
    assign fail_cnt   = fail_cnt_q;
    assign digit_cnt  = digit_cnt_q;
    assign state      = state_q;
endmodule

// File: doc/lock_ctrl.md
Name: lock_ctrl

Overview:
- Sequencing controller for the keypad digital lock.
- Accepts one 4-bit digit per handshake and assembles a DIGITS-long entry, oldest digit in the MS nibble.
- Compares the entry against a stored code and drives a timed unlock pulse.
- Counts failed attempts, enforces a lockout period, and allows the code to be reprogrammed while open.

Parameters:
- DIGITS, 4, digits per code (1..7); code/entry width 4*DIGITS.
- DEFAULT_CODE, 16'h0568, code loaded at reset (first digit in MS nibble).
- UNLOCK_CYCLES, 16, cycles unlock stays high (>=1).
- MAX_FAILS, 3, consecutive mismatches that trigger lockout (1..15).
- LOCKOUT_CYCLES, 64, lockout duration in cycles (>=1).
- ENTRY_TIMEOUT, 32, idle cycles before a partial entry is discarded (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- key_valid  in  1  digit strobe.
- key_digit  in  4  digit value 0..15; all values are legal.
- key_ready  out  1  controller accepts a digit this cycle.
- key_clear  in  1  discards the partial entry.
- prog_en  in  1  request to reprogram the code; honoured only in OPEN.
- unlock  out  1  lock open.
- locked_out  out  1  lockout active.
- fail_cnt  out  4  consecutive failed attempts.
- digit_cnt  out  3  digits held in the current entry.
- state  out  3  FSM state: ENTRY=0, CHECK=1, OPEN=2, PROG=3, LOCKOUT=4.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=ENTRY; code register=DEFAULT_CODE; entry, digit_cnt, fail_cnt and timer cleared.
  - unlock=0, locked_out=0, key_ready=1.
- Handshake:
  - A digit is accepted on a rising edge where key_valid&key_ready.
  - key_valid while key_ready=0 is dropped with no side effect.
  - key_ready=1 only in ENTRY and PROG.
- Digit accept: entry <= {entry[4*DIGITS-5:0], key_digit}; digit_cnt+1.
- key_clear (ENTRY/PROG):
  - Clears entry and digit_cnt; wins over a same-cycle key_valid.
  - In PROG it also aborts to ENTRY, leaving the code unchanged.
- ENTRY: the accept that makes digit_cnt==DIGITS moves to CHECK on the same edge; digit_cnt returns to 0.
- CHECK (exactly 1 cycle), compare entry against code:
  - Match: -> OPEN; fail_cnt=0; timer loaded with UNLOCK_CYCLES.
  - Mismatch and fail_cnt+1==MAX_FAILS: -> LOCKOUT; fail_cnt=MAX_FAILS; timer loaded with LOCKOUT_CYCLES.
  - Other mismatch: -> ENTRY; fail_cnt+1.
  - Entry register cleared on exit in every case.
- Latency: last digit accepted at edge T -> CHECK during T..T+1 -> unlock high from edge T+1 (registered) for exactly UNLOCK_CYCLES cycles.
- OPEN:
  - unlock=1; timer decrements each cycle.
  - Timer expiry -> ENTRY, unlock=0.
  - prog_en=1 -> PROG on the next edge; unlock drops; timer discarded.
  - prog_en has priority over expiry on the same cycle.
- PROG:
  - unlock=0; collects DIGITS digits as in ENTRY.
  - On the final accept: code <= new entry, -> ENTRY, fail_cnt=0.
  - No timeout unless the optional feature is compiled in.
- LOCKOUT:
  - locked_out=1; key_ready=0; timer decrements.
  - Expiry -> ENTRY; fail_cnt=0; locked_out=0.
- Outputs:
  - unlock and locked_out are registered and glitch-free.
  - state, digit_cnt and fail_cnt mirror internal registers.
- Reset mid-operation: all of the above return to reset values immediately, including the code register (reprogrammed codes are lost).
- Timers: single shared down-counter sized for max(UNLOCK_CYCLES, LOCKOUT_CYCLES, ENTRY_TIMEOUT); no wrap.
- Counter limits: fail_cnt never exceeds MAX_FAILS; digit_cnt never exceeds DIGITS-1 while visible.

Optional Feature:
- LOCK_ENTRY_TIMEOUT_EN defined:
  - In ENTRY/PROG with digit_cnt>0, the timer reloads to ENTRY_TIMEOUT on every accept.
  - After ENTRY_TIMEOUT cycles without an accept, the entry and digit_cnt are cleared.
  - PROG timing out returns to ENTRY with the code unchanged.
  - A timeout does not increment fail_cnt.
- Undefined: partial entries persist indefinitely; ENTRY_TIMEOUT is unused and no logic is generated for it.

Test Plan:
1. Reset, enter 0,5,6,8 one per cycle -> CHECK one cycle, unlock=1 from the edge after the 4th accept for 16 cycles; fail_cnt=0; state returns to 0.
2. Enter 1,2,3,4 three times -> fail_cnt 1 then 2, then state=4 and locked_out=1 for 64 cycles; key_ready=0; digits sent during lockout ignored; afterwards fail_cnt=0, and 0,5,6,8 unlocks.
3. Unlock with 0568, pulse prog_en, enter 9,3,1,7 -> code=16'h9317; 0,5,6,8 gives fail_cnt=1; 9,3,1,7 unlocks.
4. Enter 0,5, assert key_clear together with key_valid(6) -> digit_cnt=0, 6 discarded; then 0,5,6,8 unlocks. Also key_clear in PROG after 2 digits -> state=0, code unchanged.
5. Assert rst asynchronously during OPEN (mid-count) after reprogramming to 9317 -> unlock=0 without waiting for clk; afterwards 0,5,6,8 unlocks.
6. With LOCK_ENTRY_TIMEOUT_EN: enter 0,5, idle 32 cycles -> digit_cnt=0, fail_cnt unchanged. Without the macro: the same idle period leaves digit_cnt=2, and 6,8 then unlocks.
